alu_commit: RTL

Result-commit stage directly downstream of the 16-bit add/sub/X unit and the other ALU function units. It registers the selected ALU result, owns the architectural EX register (whose value feeds back as the EXin operand of ADX/SBX), and evaluates the eight IF-class conditions from the comparator flags. It implements DCPU-16 conditional skip chaining: a failed IF discards the next instruction, and keeps discarding for as long as the discarded instructions are IFs. Output is one registered stage with a valid/ready handshake toward register writeback.

---
 rtl/alu_commit_if.sv | 37 +++
 rtl/alu_commit.sv | 78 +++++++
 2 files changed

// File: rtl/alu_commit_if.sv
// Handshake and data bundle between the ALU function units, the commit stage and
// register writeback. The slave modport is the commit stage; master is its environment.
interface alu_commit_if;
  // Valid/ready: a beat transfers on any rising edge where valid && ready. The sender
  // holds valid and its payload stable until that edge. ready may depend on the
  // receiver's own state, but never on valid in the same cycle.
  logic        in_valid;
  logic        in_ready;
  logic        is_if;
  logic [2:0]  cond;
  logic        dst_we;
  logic        dst_is_ex;
  logic        ex_we;
  logic [15:0] q;
  logic [15:0] ex_in;
  logic        eq;
  logic        lt;
  logic        un;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic        out_we;
  logic        out_skipped;

  modport master (
    output in_valid, is_if, cond, dst_we, dst_is_ex, ex_we, q, ex_in, eq, lt, un,
    output out_ready,
    input  in_ready, out_valid, out_q, out_we, out_skipped
  );

  modport slave (
    input  in_valid, is_if, cond, dst_we, dst_is_ex, ex_we, q, ex_in, eq, lt, un,
    input  out_ready,
    output in_ready, out_valid, out_q, out_we, out_skipped
  );
endinterface

// File: rtl/alu_commit.sv
// ALU result commit stage: registers the selected result, owns architectural EX and
// runs the DCPU-16 conditional skip chain (a failed IF discards following IFs + one).
module alu_commit (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  alu_commit_if.slave   bus,
  output logic [15:0]   ex_q,
  output logic          skipping
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  state_t state;
  logic   accept;
  logic   cond_true;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign skipping     = (state == ST_SKIP);

  // eq is the zero flag of the AND result for IFB/IFC, and of b-a for the rest.
  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'd0: cond_true = !bus.eq;
      3'd1: cond_true = bus.eq;
      3'd2: cond_true = bus.eq;
      3'd3: cond_true = !bus.eq;
      3'd4: cond_true = !bus.lt && !bus.eq;
      3'd5: cond_true = !bus.un && !bus.eq;
      3'd6: cond_true = bus.lt;
      3'd7: cond_true = bus.un;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_RUN;
      bus.out_valid   <= 1'b0;
      bus.out_q       <= 16'h0000;
      bus.out_we      <= 1'b0;
      bus.out_skipped <= 1'b0;
      ex_q            <= 16'h0000;
    end else if (flush) begin
      // Any accept in this cycle is dropped; EX keeps its committed value.
      bus.out_valid <= 1'b0;
      state         <= ST_RUN;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_q     <= bus.q;
      if (state == ST_SKIP) begin
        bus.out_skipped <= 1'b1;
        bus.out_we      <= 1'b0;
        state           <= bus.is_if ? ST_SKIP : ST_RUN;
      end else begin
        bus.out_skipped <= 1'b0;
        bus.out_we      <= bus.dst_we && !bus.dst_is_ex && !bus.is_if;
        if (bus.is_if && !cond_true) begin
          state <= ST_SKIP;
        end
        // An explicit write to EX wins over the arithmetic side effect.
        if (bus.dst_we && bus.dst_is_ex) begin
          ex_q <= bus.q;
        end else if (bus.ex_we) begin
          ex_q <= bus.ex_in;
        end
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
